line_buffer_sequencer: RTL and testbench

Control sequencer for the 4-line, 1-bit-per-pixel binarized line buffer bank in the ball-detector path. Generates the shared write/read column address, the one-hot write enables, and the tap-rotation select from the camera's h_sync/v_sync/pixel_valid stream. It also tracks priming, so downstream 3x1 column filtering only consumes taps once three complete lines sit above the current one. Replaces the per-buffer pointer logic clocked directly off h_sync with a fully synchronous, resettable controller on bit_clk.

---
 rtl/line_buffer_sequencer.sv | 122 ++++++++++++
 tb/tb_line_buffer_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: column address, write enables and tap rotation
// for the binarized line buffer bank in the ball-detector path.
module line_buffer_sequencer #(
  parameter int NUM_BUFFERS = 4,
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10,
  localparam int SW = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic               bit_clk,
  input  logic               reset_n,
  input  logic               v_sync,
  input  logic               h_sync,
  input  logic               pixel_valid,
  output logic [X_BITS-1:0]  x_cont,
  output logic [Y_BITS-1:0]  y_cont,
  output logic [SW-1:0]      wr_sel,
  output logic [NUM_BUFFERS-1:0] wr_en,
  output logic [SW-1:0]      rd_rot,
  output logic [X_BITS-1:0]  tap_x,
  output logic               taps_valid,
  output logic               line_done,
  output logic               frame_done,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, GAP, LINE} state_e;

  state_e            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q;
  logic [SW-1:0]     sel_q, fill_q;
  logic [SW-1:0]     rot_q;
  logic [X_BITS-1:0] tap_x_q;
  logic              tv_q, ld_q, fd_q, ovr_q;

  logic              from_idle, leave_idle;
  logic              enter_line, end_line;
  logic              accept, x_ok, y_ok, do_wr;
  logic [SW-1:0]     sel_cur, fill_cur;
  logic [Y_BITS-1:0] y_cur;

  always_comb begin
    state_d = state_q;
    if (!v_sync)     state_d = IDLE;
    else if (h_sync) state_d = LINE;
    else             state_d = GAP;
  end

  // Counters read as cleared on the very cycle a frame starts
  assign from_idle  = (state_q == IDLE);
  assign leave_idle = from_idle && (state_d != IDLE);
  assign sel_cur    = from_idle ? '0 : sel_q;
  assign fill_cur   = from_idle ? '0 : fill_q;
  assign y_cur      = from_idle ? '0 : y_q;

  assign enter_line = (state_d == LINE) && (state_q != LINE);
  assign end_line   = (state_q == LINE) && (state_d != LINE);

  assign accept = reset_n && ((state_q == LINE) || enter_line)
                  && h_sync && v_sync && pixel_valid;
  assign x_ok   = x_q < X_BITS'(LINE_WIDTH);
  assign y_ok   = y_cur < Y_BITS'(FRAME_LINES);
  assign do_wr  = accept && x_ok && y_ok;

  always_comb begin
    x_d = x_q;
    if (!h_sync || !v_sync)  x_d = '0;
    else if (accept && x_ok) x_d = x_q + X_BITS'(1);
  end

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      fill_q  <= '0;
      rot_q   <= '0;
      tap_x_q <= '0;
      tv_q    <= 1'b0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      if (end_line) begin
        sel_q  <= sel_cur + SW'(1);
        y_q    <= (y_cur == Y_BITS'(FRAME_LINES)) ?
                  y_cur : y_cur + Y_BITS'(1);
        fill_q <= (fill_cur == SW'(NUM_BUFFERS - 1)) ?
                  fill_cur : fill_cur + SW'(1);
      end else if (leave_idle) begin
        sel_q  <= '0;
        y_q    <= '0;
        fill_q <= '0;
      end
      if ((accept && !x_ok) || (enter_line && !y_ok))
        ovr_q <= 1'b1;
      // Taps follow the RAM write by its one-cycle read latency
      tv_q    <= do_wr && (fill_cur == SW'(NUM_BUFFERS - 1));
      tap_x_q <= x_q;
      rot_q   <= sel_cur;
      ld_q    <= end_line;
      fd_q    <= !from_idle && !v_sync;
    end
  end

  assign wr_en      = do_wr ? (NUM_BUFFERS'(1) << sel_cur) : '0;
  assign x_cont     = x_q;
  assign y_cont     = y_q;
  assign wr_sel     = sel_cur;
  assign rd_rot     = rot_q;
  assign tap_x      = tap_x_q;
  assign taps_valid = tv_q;
  assign line_done  = ld_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: directed frames with a tap scoreboard
// covering priming, rotation, overrun, frame abort and reset.
module tb_line_buffer_sequencer;

  localparam int NB = 4;
  localparam int LW = 640;
  localparam int XB = 10;
  localparam int YB = 10;
  localparam int SW = 2;

  logic bit_clk = 1'b0;
  logic reset_n = 1'b0;
  logic v_sync = 1'b0;
  logic h_sync = 1'b0;
  logic pixel_valid = 1'b0;

  logic [XB-1:0] x_cont, tap_x;
  logic [YB-1:0] y_cont;
  logic [SW-1:0] wr_sel, rd_rot;
  logic [NB-1:0] wr_en;
  logic taps_valid, line_done, frame_done, overrun;

  int n_chk = 0;
  int n_fail = 0;
  int fline = 0;
  int col = 0;
  int wr_cnt = 0;

  typedef struct {
    int x;
    int rot;
  } tap_t;
  tap_t q[$];

  always #5 bit_clk = ~bit_clk;

  line_buffer_sequencer #(
    .NUM_BUFFERS(NB), .LINE_WIDTH(LW), .FRAME_LINES(480),
    .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .bit_clk(bit_clk), .reset_n(reset_n),
    .v_sync(v_sync), .h_sync(h_sync), .pixel_valid(pixel_valid),
    .x_cont(x_cont), .y_cont(y_cont), .wr_sel(wr_sel), .wr_en(wr_en),
    .rd_rot(rd_rot), .tap_x(tap_x), .taps_valid(taps_valid),
    .line_done(line_done), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic pv);
    @(negedge bit_clk);
    v_sync = v;
    h_sync = h;
    pixel_valid = pv;
    #1;
    if (taps_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("tap_spurious", 32'(taps_valid), 0);
      end else begin
        tap_t t;
        t = q.pop_front();
        chk("tap_x", 32'(tap_x), t.x);
        chk("rd_rot", 32'(rd_rot), t.rot);
      end
    end
  endtask

  task automatic pix(input logic pv);
    int sel;
    logic exp_wr;
    sel = fline % NB;
    exp_wr = pv && (col < LW);
    cyc(1'b1, 1'b1, pv);
    chk("x_cont", 32'(x_cont), (col < LW) ? col : LW);
    chk("wr_en", 32'(wr_en), exp_wr ? (1 << sel) : 0);
    if (wr_en != '0) wr_cnt++;
    if (exp_wr && fline >= NB - 1) q.push_back(tap_t'{col, sel});
    if (pv) col++;
  endtask

  task automatic line_start();
    cyc(1'b1, 1'b0, 1'b0);
    chk("wr_sel", 32'(wr_sel), fline % NB);
    chk("y_cont", 32'(y_cont), fline);
    wr_cnt = 0;
    col = 0;
  endtask

  task automatic line_end();
    cyc(1'b1, 1'b0, 1'b0);
    chk("line_done_early", 32'(line_done), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("line_done", 32'(line_done), 1);
    chk("frame_done_mid", 32'(frame_done), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("line_done_pulse", 32'(line_done), 0);
    chk("tap_drain", q.size(), 0);
    fline++;
  endtask

  task automatic do_line(input int n, input bit tog);
    line_start();
    for (int i = 0; i < n; i++) pix(tog ? (i % 2 == 0) : 1'b1);
    line_end();
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    fline = 0;
    col = 0;
  endtask

  task automatic frame_end();
    cyc(1'b0, 1'b0, 1'b0);
    chk("frame_done_early", 32'(frame_done), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("frame_done", 32'(frame_done), 1);
    chk("line_done_at_fend", 32'(line_done), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("frame_done_pulse", 32'(frame_done), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_x_cont", 32'(x_cont), 0);
    chk("rst_y_cont", 32'(y_cont), 0);
    chk("rst_wr_sel", 32'(wr_sel), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_rot", 32'(rd_rot), 0);
    chk("rst_tap_x", 32'(tap_x), 0);
    chk("rst_taps_valid", 32'(taps_valid), 0);
    chk("rst_line_done", 32'(line_done), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_reset_vals();
    @(negedge bit_clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Frame A: priming, overlong line, half-rate pixels
    frame_start();
    for (int l = 0; l < 4; l++) do_line(LW, 1'b0);
    chk("overrun_before", 32'(overrun), 0);
    do_line(LW + 5, 1'b0);
    chk("overrun_set", 32'(overrun), 1);
    do_line(LW, 1'b1);
    chk("wr_en_count", wr_cnt, LW / 2);
    frame_end();

    // Frame B: v_sync drops mid-line
    frame_start();
    chk("overrun_sticky", 32'(overrun), 1);
    do_line(LW, 1'b0);
    do_line(LW, 1'b0);
    line_start();
    for (int i = 0; i < 200; i++) pix(1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_x_cont", 32'(x_cont), 200);
    cyc(1'b0, 1'b1, 1'b1);
    chk("abort_line_done", 32'(line_done), 1);
    chk("abort_frame_done", 32'(frame_done), 1);
    chk("idle_wr_en", 32'(wr_en), 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("abort_ld_pulse", 32'(line_done), 0);
    chk("abort_fd_pulse", 32'(frame_done), 0);
    chk("idle_wr_en2", 32'(wr_en), 0);
    cyc(1'b0, 1'b0, 1'b0);

    // Frame C: restarts unprimed, then reset mid line 5
    frame_start();
    for (int l = 0; l < 5; l++) do_line(LW, 1'b0);
    line_start();
    for (int i = 0; i < 300; i++) pix(1'b1);
    @(negedge bit_clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    q.delete();
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge bit_clk);
    reset_n = 1'b1;

    // h_sync pulses before v_sync rises must not write
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(1'b0, 1'b1, 1'b1);
        chk("pre_vs_wr_en", 32'(wr_en), 0);
        chk("pre_vs_x_cont", 32'(x_cont), 0);
      end
      cyc(1'b0, 1'b0, 1'b0);
    end

    // Frame D: first lines after reset are unprimed
    frame_start();
    do_line(LW, 1'b0);
    do_line(LW, 1'b0);
    frame_end();
    chk("overrun_after_rst", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
